cosim_commit_queue: RTL and testbench
=====================================

// Module: cosim_commit_queue
// PURPOSE
//  Cosim-only commit capture stage, sits between the core's commit/writeback
//  ports and the Spike scoreboard. Samples every retired instruction or exception
//  (commit && !stall_exe) into a FIFO. Presents entries one at a time with a
//  valid/ready handshake, so the scoreboard can step Spike at its own pace.
//  Flags lost commits. Synthesised only under MEEP_COSIM.
// PARAMETERS
//  DEPTH          8     FIFO entries; power of 2, >=2
//  CNT_W          32    width of sequence and drop counters
//  TIMEOUT_CYCLES 4096  watchdog limit; used only with COSIM_COMMIT_TIMEOUT_EN
// PORTS
//  clk            in   1    core clock
//  rst            in   1    asynchronous reset, active-high
//  commit_i       in   1    core commit strobe
//  stall_exe_i    in   1    execute stall; when high, the commit is not sampled
//  pc_i           in   64   committed PC, already sign-extended
//  instr_i        in   32   instruction word (16-bit compressed in [15:0])
//  xreg_dest_i    in   5    destination x-register
//  xreg_we_i      in   1    integer register-file write enable
//  commit_data_i  in   64   writeback data
//  excep_i        in   1    exception; core or CSR, ORed upstream
//  cause_i        in   64   mcause value, meaningful when excep_i is high
//  out_valid_o    out  1    head entry valid
//  out_ready_i    in   1    scoreboard accepts the head entry
//  out_pc_o / out_instr_o / out_dest_o / out_data_o / out_cause_o
//                 out  64/32/5/64/64  head entry fields
//  out_wr_valid_o out  1    captured (xreg_we_i && xreg_dest_i!=0)
//  out_excep_o    out  1    head entry is an exception
//  out_seq_o      out  CNT_W  sequence number of the head entry; first entry = 0
//  overflow_o     out  1    sticky: at least one commit was dropped
//  drop_cnt_o     out  CNT_W  number of dropped commits; saturates at all-ones
//  level_o        out  $clog2(DEPTH)+1  current occupancy
//  timeout_o      out  1    sticky watchdog flag; tied 0 if macro is absent
// BEHAVIOUR
//  - Reset (async assert, sync release): pointers, level, seq, drop_cnt = 0.
//    overflow_o, timeout_o, out_valid_o = 0. Entry storage is not reset; outputs
//    are don't-care while out_valid_o = 0.
//  - push = commit_i && !stall_exe_i. pop = out_valid_o && out_ready_i.
//  - Push writes the entry at wr_ptr and tags it with seq; seq then increments and
//    wraps modulo 2^CNT_W. Pointers wrap modulo DEPTH.
//  - Output comes directly from storage at rd_ptr (first-word-fall-through).
//    An entry pushed in cycle N is visible with out_valid_o=1 in cycle N+1.
//  - Empty + pop: impossible, because out_valid_o=0. Empty + push: level -> 1.
//  - Push+pop together: level unchanged. This holds when full: pop frees the slot
//    and the push is accepted.
//  - Full, push, no pop: commit is dropped. wr_ptr, seq and storage are unchanged.
//    overflow_o goes to 1 (sticky until rst). drop_cnt_o increments with saturation.
//  - out_* fields must remain stable while out_valid_o && !out_ready_i.
//  - Reset mid-stream flushes all entries. The first push after reset gets seq 0.
//  - Exceptions are queued like commits; data and dest are captured verbatim.
// CONFIGURATION
//  COSIM_COMMIT_TIMEOUT_EN defined:
//   - Idle counter clears on every push.
//   - While no push occurs, the counter increments and saturates at TIMEOUT_CYCLES.
//   - Reaching TIMEOUT_CYCLES sets timeout_o sticky and issues one $error naming
//     the last seq.
//   - The counter is held at 0 until the first push after reset, so boot is
//     not flagged.
//  Not defined: no counter; timeout_o tied 0.
// TESTING
//  1 Single push pc=0x80000000, instr=0x00000013 and ready=1 -> valid high the
//    next cycle, seq=0, popped the cycle after, level back to 0.
//  2 Push with commit_i=1 and stall_exe_i=1 -> no entry; level stays 0; seq
//    not consumed.
//  3 Hold ready=0; push 10 commits with DEPTH=8 -> level=8, overflow_o=1,
//    drop_cnt=2. Drain order is seq 0..7; stored data matches inputs.
//  4 Full, push+pop in the same cycle -> level stays 8; the new entry is seq 8
//    and is delivered last.
//  5 Push x0 write (dest=0, we=1) and exception cause=0x2 -> out_wr_valid_o=0;
//    out_excep_o=1 with out_cause_o=0x2.
//  6 TIMEOUT_EN with TIMEOUT_CYCLES=16: one push, then idle 16 cycles ->
//    timeout_o=1. Assert rst mid-stream -> all outputs 0 immediately; queue empty.

Source files
------------

// File: rtl/cosim_commit_queue.sv
// Commit capture FIFO between the core retire ports and the cosim scoreboard.
// Optional idle watchdog under COSIM_COMMIT_TIMEOUT_EN.
module cosim_commit_queue #(
    parameter int DEPTH          = 8,
    parameter int CNT_W          = 32,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     commit_i,
    input  logic                     stall_exe_i,
    input  logic [63:0]              pc_i,
    input  logic [31:0]              instr_i,
    input  logic [4:0]               xreg_dest_i,
    input  logic                     xreg_we_i,
    input  logic [63:0]              commit_data_i,
    input  logic                     excep_i,
    input  logic [63:0]              cause_i,
    output logic                     out_valid_o,
    input  logic                     out_ready_i,
    output logic [63:0]              out_pc_o,
    output logic [31:0]              out_instr_o,
    output logic [4:0]               out_dest_o,
    output logic [63:0]              out_data_o,
    output logic [63:0]              out_cause_o,
    output logic                     out_wr_valid_o,
    output logic                     out_excep_o,
    output logic [CNT_W-1:0]         out_seq_o,
    output logic                     overflow_o,
    output logic [CNT_W-1:0]         drop_cnt_o,
    output logic [$clog2(DEPTH):0]   level_o,
    output logic                     timeout_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    typedef struct packed {
        logic [63:0]      pc;
        logic [31:0]      instr;
        logic [4:0]       dest;
        logic [63:0]      data;
        logic [63:0]      cause;
        logic             wr_valid;
        logic             excep;
        logic [CNT_W-1:0] seq;
    } entry_t;

    entry_t           mem [DEPTH];
    entry_t           head;
    entry_t           wr_entry;
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [LW-1:0]    level;
    logic [CNT_W-1:0] seq;
    logic [CNT_W-1:0] drop_cnt;
    logic             overflow;
    logic             push;
    logic             pop;
    logic             full;
    logic             accept;
    logic             drop;

    assign push   = commit_i && !stall_exe_i;
    assign pop    = out_valid_o && out_ready_i;
    assign full   = (level == LW'(DEPTH));
    // A pop in the same cycle frees the slot, so a full queue still accepts.
    assign accept = push && (!full || pop);
    assign drop   = push && full && !pop;

    always_comb begin
        wr_entry          = '0;
        wr_entry.pc       = pc_i;
        wr_entry.instr    = instr_i;
        wr_entry.dest     = xreg_dest_i;
        wr_entry.data     = commit_data_i;
        wr_entry.cause    = cause_i;
        wr_entry.wr_valid = xreg_we_i && (xreg_dest_i != 5'd0);
        wr_entry.excep    = excep_i;
        wr_entry.seq      = seq;
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            mem[wr_ptr] <= wr_entry;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            seq      <= '0;
            drop_cnt <= '0;
            overflow <= 1'b0;
        end else begin
            if (accept) begin
                wr_ptr <= wr_ptr + AW'(1);
                seq    <= seq + CNT_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (accept && !pop) begin
                level <= level + LW'(1);
            end else if (pop && !accept) begin
                level <= level - LW'(1);
            end
            if (drop) begin
                overflow <= 1'b1;
                if (drop_cnt != '1) begin
                    drop_cnt <= drop_cnt + CNT_W'(1);
                end
            end
        end
    end

    assign head           = mem[rd_ptr];
    assign out_valid_o    = (level != '0);
    assign out_pc_o       = head.pc;
    assign out_instr_o    = head.instr;
    assign out_dest_o     = head.dest;
    assign out_data_o     = head.data;
    assign out_cause_o    = head.cause;
    assign out_wr_valid_o = head.wr_valid;
    assign out_excep_o    = head.excep;
    assign out_seq_o      = head.seq;
    assign overflow_o     = overflow;
    assign drop_cnt_o     = drop_cnt;
    assign level_o        = level;

`ifdef COSIM_COMMIT_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TW-1:0]    idle_cnt;
    logic             armed;
    logic             timeout_q;
    logic [CNT_W-1:0] last_seq;

    // Disarmed until the first push so a quiet boot is not flagged.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idle_cnt  <= '0;
            armed     <= 1'b0;
            timeout_q <= 1'b0;
            last_seq  <= '0;
        end else if (push) begin
            idle_cnt <= '0;
            armed    <= 1'b1;
            if (accept) begin
                last_seq <= seq;
            end
        end else if (armed && idle_cnt != TW'(TIMEOUT_CYCLES)) begin
            idle_cnt <= idle_cnt + TW'(1);
            if (idle_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
                timeout_q <= 1'b1;
                $error("cosim_commit_queue: no commit since seq %0d",
                       last_seq);
            end
        end
    end

    assign timeout_o = timeout_q;
`else
    // Constant 0 for any legal configuration.
    assign timeout_o = (TIMEOUT_CYCLES < 0);
`endif

endmodule

// File: tb/tb_cosim_commit_queue.sv
// Directed bench for cosim_commit_queue (DEPTH=8, CNT_W=32).
module tb_cosim_commit_queue;

    logic        clk = 1'b0;
    logic        rst;
    logic        commit_i;
    logic        stall_exe_i;
    logic [63:0] pc_i;
    logic [31:0] instr_i;
    logic [4:0]  xreg_dest_i;
    logic        xreg_we_i;
    logic [63:0] commit_data_i;
    logic        excep_i;
    logic [63:0] cause_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [63:0] out_pc_o;
    logic [31:0] out_instr_o;
    logic [4:0]  out_dest_o;
    logic [63:0] out_data_o;
    logic [63:0] out_cause_o;
    logic        out_wr_valid_o;
    logic        out_excep_o;
    logic [31:0] out_seq_o;
    logic        overflow_o;
    logic [31:0] drop_cnt_o;
    logic [3:0]  level_o;
    logic        timeout_o;

    int n_tests = 0;
    int n_fail  = 0;

    cosim_commit_queue #(
        .DEPTH(8),
        .CNT_W(32),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .commit_i(commit_i),
        .stall_exe_i(stall_exe_i),
        .pc_i(pc_i),
        .instr_i(instr_i),
        .xreg_dest_i(xreg_dest_i),
        .xreg_we_i(xreg_we_i),
        .commit_data_i(commit_data_i),
        .excep_i(excep_i),
        .cause_i(cause_i),
        .out_valid_o(out_valid_o),
        .out_ready_i(out_ready_i),
        .out_pc_o(out_pc_o),
        .out_instr_o(out_instr_o),
        .out_dest_o(out_dest_o),
        .out_data_o(out_data_o),
        .out_cause_o(out_cause_o),
        .out_wr_valid_o(out_wr_valid_o),
        .out_excep_o(out_excep_o),
        .out_seq_o(out_seq_o),
        .overflow_o(overflow_o),
        .drop_cnt_o(drop_cnt_o),
        .level_o(level_o),
        .timeout_o(timeout_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [63:0] got,
                         input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [63:0] pc, input logic [31:0] ins,
                         input logic [4:0] dst, input logic we,
                         input logic [63:0] dat, input logic exc,
                         input logic [63:0] cau);
        commit_i      = 1'b1;
        pc_i          = pc;
        instr_i       = ins;
        xreg_dest_i   = dst;
        xreg_we_i     = we;
        commit_data_i = dat;
        excep_i       = exc;
        cause_i       = cau;
    endtask

    initial begin
        rst = 1'b1;
        commit_i = 0; stall_exe_i = 0; pc_i = 0; instr_i = 0;
        xreg_dest_i = 0; xreg_we_i = 0; commit_data_i = 0;
        excep_i = 0; cause_i = 0; out_ready_i = 0;
        tick();
        tick();
        check("rst_valid", out_valid_o, 0);
        check("rst_level", level_o, 0);
        check("rst_ovf", overflow_o, 0);
        check("rst_drop", drop_cnt_o, 0);
        check("rst_tmo", timeout_o, 0);
        rst = 1'b0;
        tick();

        // single push, popped next cycle
        out_ready_i = 1;
        drive(64'h8000_0000, 32'h13, 5'd0, 0, 64'h0, 0, 64'h0);
        tick();
        commit_i = 0;
        check("t1_valid", out_valid_o, 1);
        check("t1_seq", out_seq_o, 0);
        check("t1_pc", out_pc_o, 64'h8000_0000);
        check("t1_instr", out_instr_o, 32'h13);
        check("t1_level", level_o, 1);
        tick();
        check("t1_empty", out_valid_o, 0);
        check("t1_level0", level_o, 0);

        // stalled commit not sampled
        drive(64'h8000_0004, 32'h13, 5'd1, 1, 64'h1, 0, 64'h0);
        stall_exe_i = 1;
        tick();
        commit_i = 0; stall_exe_i = 0;
        check("t2_level", level_o, 0);
        check("t2_valid", out_valid_o, 0);
        drive(64'h8000_0008, 32'h13, 5'd1, 1, 64'h1, 0, 64'h0);
        tick();
        commit_i = 0;
        check("t2_seq", out_seq_o, 1);
        tick();

        // reset so the fill starts at seq 0
        rst = 1;
        tick();
        rst = 0;
        tick();

        // fill past full with ready low
        out_ready_i = 0;
        for (int i = 0; i < 10; i++) begin
            drive(64'h1000 + 64'(i * 4), 32'h100 + 32'(i), 5'(i + 1), 1,
                  64'(i * 'h11), 0, 64'h0);
            tick();
        end
        commit_i = 0;
        check("t3_level", level_o, 8);
        check("t3_ovf", overflow_o, 1);
        check("t3_drop", drop_cnt_o, 2);
        check("t3_seq0", out_seq_o, 0);
        tick();
        check("t3_hold_seq", out_seq_o, 0);
        check("t3_hold_pc", out_pc_o, 64'h1000);
        check("t3_hold_wrv", out_wr_valid_o, 1);
        check("t3_hold_dst", out_dest_o, 1);

        // full: push+pop together is accepted
        drive(64'hdead_0000, 32'h0bad, 5'd7, 1, 64'h99, 0, 64'h0);
        out_ready_i = 1;
        tick();
        commit_i = 0;
        check("t4_level", level_o, 8);
        check("t4_drop", drop_cnt_o, 2);
        for (int k = 1; k < 8; k++) begin
            check("t4_seq", out_seq_o, 64'(k));
            check("t4_pc", out_pc_o, 64'h1000 + 64'(k * 4));
            check("t4_data", out_data_o, 64'(k * 'h11));
            check("t4_instr", out_instr_o, 32'h100 + 32'(k));
            check("t4_dest", out_dest_o, 64'(k + 1));
            tick();
        end
        check("t4_last_seq", out_seq_o, 8);
        check("t4_last_pc", out_pc_o, 64'hdead_0000);
        check("t4_last_data", out_data_o, 64'h99);
        tick();
        check("t4_empty", out_valid_o, 0);
        check("t4_level0", level_o, 0);

        // x0 write and exception entries
        out_ready_i = 0;
        drive(64'h2000, 32'h0000_0093, 5'd0, 1, 64'h7, 0, 64'h0);
        tick();
        check("t5_x0_wrv", out_wr_valid_o, 0);
        check("t5_x0_exc", out_excep_o, 0);
        check("t5_x0_seq", out_seq_o, 9);
        drive(64'h2004, 32'h0000_0073, 5'd3, 1, 64'h55, 1, 64'h2);
        out_ready_i = 1;
        tick();
        commit_i = 0; excep_i = 0;
        check("t5_level", level_o, 1);
        check("t5_exc", out_excep_o, 1);
        check("t5_cause", out_cause_o, 64'h2);
        check("t5_dest", out_dest_o, 3);
        check("t5_data", out_data_o, 64'h55);
        check("t5_seq", out_seq_o, 10);
        tick();
        check("t5_empty", out_valid_o, 0);

        // idle watchdog, then async reset mid-stream
        repeat (16) tick();
`ifdef COSIM_COMMIT_TIMEOUT_EN
        check("t6_tmo", timeout_o, 1);
`else
        check("t6_tmo", timeout_o, 0);
`endif
        out_ready_i = 0;
        for (int i = 0; i < 3; i++) begin
            drive(64'h3000 + 64'(i * 4), 32'h13, 5'd2, 1, 64'h1, 0, 64'h0);
            tick();
        end
        commit_i = 0;
        check("t6_level3", level_o, 3);
        #2;
        rst = 1;
        #1;
        check("t6_rst_valid", out_valid_o, 0);
        check("t6_rst_level", level_o, 0);
        check("t6_rst_ovf", overflow_o, 0);
        check("t6_rst_drop", drop_cnt_o, 0);
        check("t6_rst_tmo", timeout_o, 0);
        tick();
        rst = 0;
        drive(64'h4000, 32'h13, 5'd4, 1, 64'h44, 0, 64'h0);
        tick();
        commit_i = 0;
        check("t6_post_seq", out_seq_o, 0);
        check("t6_post_level", level_o, 1);
        check("t6_post_pc", out_pc_o, 64'h4000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
